afifo_rd_stream: RTL

Read-side stage placed directly downstream of the asynchronous FIFO's pop interface, in the read clock domain. It issues `pop` whenever the FIFO is non-empty and local space exists. It absorbs the FIFO's one-cycle read latency (`pop_data` qualified by `pop_data_vld_r`) in a small skid buffer. It presents the data to the consumer as a valid/ready stream at full throughput (one beat per cycle sustained).

---
 rtl/afifo_pkg.sv | 29 ++
 rtl/afifo_rd_stream_rd_skid_buf.sv | 103 ++++++++++
 rtl/afifo_rd_stream.sv | 109 ++++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// -----------------------------------------------------------------------------
// afifo_pkg
//
// Shared constants and helpers for the asynchronous-FIFO read-side stream
// stage.
//
// Contents:
//   AFIFO_RD_STREAM_DEPTH_MIN : smallest legal skid depth (one beat per cycle)
//   AFIFO_RD_STREAM_DEPTH_MAX : largest supported skid depth
//   afifo_cnt_width()         : width of an occupancy counter that can hold
//                               the value DEPTH itself
//   afifo_idx_width()         : width of a read/write index into DEPTH slots
// -----------------------------------------------------------------------------
package afifo_pkg;

   localparam int AFIFO_RD_STREAM_DEPTH_MIN = 2;
   localparam int AFIFO_RD_STREAM_DEPTH_MAX = 8;

   // Occupancy runs 0..DEPTH inclusive, so it needs one bit more than an index.
   function automatic int afifo_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Indices run 0..DEPTH-1. DEPTH is at least 2, so this is never zero.
   function automatic int afifo_idx_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage : afifo_pkg

// File: rtl/afifo_rd_stream_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
//
// DEPTH-entry circular store used as the skid buffer of afifo_rd_stream.
// DEPTH need not be a power of two, so both indices wrap by compare-and-clear
// rather than by letting the counter overflow.
//
// Ports:
//   clk       in   read-domain clock
//   rst       in   asynchronous active-high reset
//   flush     in   clear count and both indices at the next edge; blocks the
//                  write of that cycle
//   enq       in   write enq_data at the write index
//   enq_data  in   W-bit beat to store
//   deq       in   retire the entry at the read index (caller guarantees
//                  count != 0)
//   count     out  number of stored entries, 0..DEPTH
//   head_data out  entry at the read index (don't-care while count == 0)
// -----------------------------------------------------------------------------
module rd_skid_buf
   import afifo_pkg::*;
#(
   parameter  int W     = 32,
   parameter  int DEPTH = 2,
   localparam int CNT_W = afifo_cnt_width(DEPTH),
   localparam int IDX_W = afifo_idx_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             enq,
   input  logic [W-1:0]     enq_data,
   input  logic             deq,
   output logic [CNT_W-1:0] count,
   output logic [W-1:0]     head_data
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [IDX_W-1:0] wa_q, wa_d;
   logic [IDX_W-1:0] ra_q, ra_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Advance an index by one slot, wrapping after the last real entry.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(DEPTH - 1)) begin
         return '0;
      end
      return idx + IDX_W'(1);
   endfunction

   // NOTE: every variable gets its hold value first so no path through the
   // block leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      wa_d    = wa_q;
      ra_d    = ra_q;
      count_d = count_q;
      if (flush) begin
         wa_d    = '0;
         ra_d    = '0;
         count_d = '0;
      end else begin
         if (enq) begin
            wa_d = idx_inc(wa_q);
         end
         if (deq) begin
            ra_d = idx_inc(ra_q);
         end
         // Simultaneous write and read leave the occupancy unchanged.
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wa_q    <= '0;
         ra_q    <= '0;
         count_q <= '0;
      end else begin
         wa_q    <= wa_d;
         ra_q    <= ra_d;
         count_q <= count_d;
      end
   end

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, and leaving it unreset lets it map onto plain
   // register-file cells.
   always_ff @(posedge clk) begin
      if (enq && !flush) begin
         mem_q[wa_q] <= enq_data;
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[ra_q];

endmodule : rd_skid_buf

// File: rtl/afifo_rd_stream.sv
// -----------------------------------------------------------------------------
// afifo_rd_stream
//
// Read-side stage directly downstream of an asynchronous FIFO's pop port, in
// the read clock domain. It pops whenever the FIFO is non-empty and there is
// room for the beat, absorbs the FIFO's one-cycle read latency in a small
// skid buffer, and presents a valid/ready stream that sustains one beat per
// cycle.
//
// Optional feature (compile-time macro):
//   AFIFO_RD_STREAM_BYPASS_EN  when defined, a beat arriving while the buffer
//                              is empty is shown on the stream in its arrival
//                              cycle and is not stored if it is accepted
//                              there (pop-to-valid latency 1 instead of 2).
//
// Parameters:
//   W      data width, equal to the FIFO's data width
//   DEPTH  skid buffer entries, 2..8
//
// Ports:
//   clk            in   read-domain clock (FIFO rclk)
//   rst            in   asynchronous active-high reset
//   flush          in   drop every buffered and in-flight beat
//   empty_r        in   FIFO empty flag
//   pop            out  FIFO pop request (combinational)
//   pop_data       in   FIFO read data, valid with pop_data_vld_r
//   pop_data_vld_r in   FIFO read-data valid, one cycle after pop
//   out_vld        out  stream valid
//   out_rdy        in   stream ready
//   out_data       out  stream data, stable while out_vld & ~out_rdy
//   level          out  number of buffered entries
// -----------------------------------------------------------------------------
module afifo_rd_stream
   import afifo_pkg::*;
#(
   parameter  int W     = 32,
   parameter  int DEPTH = 2,
   localparam int CNT_W = afifo_cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             empty_r,
   output logic             pop,
   input  logic [W-1:0]     pop_data,
   input  logic             pop_data_vld_r,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [W-1:0]     out_data,
   output logic [CNT_W-1:0] level
);

   logic [CNT_W-1:0] count;
   logic [W-1:0]     head_data;
   logic             deq;
   logic             buf_enq;
   logic             buf_deq;
   logic [CNT_W:0]   occupancy;

   // A beat already returning from the FIFO holds a slot even though it is
   // not stored yet; counting it here means no beat can ever arrive to a full
   // buffer.
   assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pop_data_vld_r};

   assign deq = out_vld & out_rdy;

   // A dequeue in this cycle frees a slot for the beat popped now, which is
   // what keeps the stage at one beat per cycle with only two entries.
   assign pop = ~empty_r & ~flush & ~rst &
                ((occupancy < (CNT_W + 1)'(DEPTH)) | deq);

`ifdef AFIFO_RD_STREAM_BYPASS_EN
   logic bypass_act;

   // Empty buffer and a beat on the FIFO port: show it straight away. A
   // flushed beat is never shown.
   assign bypass_act = (count == '0) & pop_data_vld_r & ~flush;

   assign out_vld  = (count != '0) | bypass_act;
   assign out_data = bypass_act ? pop_data : head_data;

   // A bypassed beat taken by the consumer this cycle is never stored; one
   // that is stalled is stored and becomes the head next cycle.
   assign buf_enq  = pop_data_vld_r & ~flush & ~(bypass_act & out_rdy);
   assign buf_deq  = (count != '0) & out_rdy;
`else
   assign out_vld  = (count != '0);
   assign out_data = head_data;
   assign buf_enq  = pop_data_vld_r & ~flush;
   assign buf_deq  = deq;
`endif

   rd_skid_buf #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .enq       (buf_enq),
      .enq_data  (pop_data),
      .deq       (buf_deq),
      .count     (count),
      .head_data (head_data)
   );

   assign level = count;

endmodule : afifo_rd_stream
